// File: rtl/retstack_pkg.sv
// Shared definitions for the return-address stack and the rp adder that consumes rp_inc.
package retstack_pkg;

    localparam logic [1:0] RP_INC_HOLD = 2'b00;
    localparam logic [1:0] RP_INC_UP   = 2'b01;
    localparam logic [1:0] RP_INC_DOWN = 2'b10;

    localparam int DEFAULT_BASE = 16384;

    typedef enum logic {
        ST_IDLE,
        ST_REFILL
    } state_t;

    // Address width that stays at least one bit even for a single-entry RAM.
    function automatic int addrWidth(input int entries);
        return (entries > 1) ? $clog2(entries) : 1;
    endfunction

endpackage

// File: rtl/subsystem_retstack_if.sv
// Request/status bundle between the control unit (master) and the return stack (slave).
interface subsystem_retstack_if #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16
);
    localparam int CW = $clog2(DEPTH + 1);

    logic             push;
    logic             pop;
    logic [WIDTH-1:0] push_data;
    logic             clr_err;
    logic             ready;
    logic [WIDTH-1:0] tos;
    logic [15:0]      rp;
    logic [1:0]       rp_inc;
    logic [CW-1:0]    count;
    logic             empty;
    logic             full;
    logic             overflow;
    logic             underflow;

    modport master (
        output push, pop, push_data, clr_err,
        input  ready, tos, rp, rp_inc, count, empty, full, overflow, underflow
    );

    modport slave (
        input  push, pop, push_data, clr_err,
        output ready, tos, rp, rp_inc, count, empty, full, overflow, underflow
    );

endinterface

// File: rtl/retstack_mem.sv
// Backing RAM for stack entries below TOS; one write port, one read port.
// Read is registered by default and combinational when RETSTACK_FAST_POP_EN is defined.
module retstack_mem #(
    parameter int WIDTH   = 16,
    parameter int ENTRIES = 15,
    parameter int AW      = 4
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem [0:ENTRIES-1];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
    end

`ifdef RETSTACK_FAST_POP_EN
    assign rdata_o = mem[raddr_i];
`else
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        rdata_q <= mem[raddr_i];
    end

    assign rdata_o = rdata_q;
`endif

endmodule

// File: rtl/subsystem_retstack.sv
// Return-address stack: TOS cached in a register, deeper entries in retstack_mem.
// Optional RETSTACK_FAST_POP_EN removes the REFILL bubble by reading the RAM combinationally.
module subsystem_retstack
    import retstack_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16,
    parameter int BASE  = DEFAULT_BASE
) (
    input logic CLK,
    input logic reset,
    subsystem_retstack_if.slave bus
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = addrWidth(DEPTH - 1);

    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] tos_q, tos_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic [1:0]       rpInc;

    logic             memWe;
    logic [AW-1:0]    memWaddr;
    logic [AW-1:0]    memRaddr;
    logic [WIDTH-1:0] memRdata;

    logic isEmpty;
    logic isFull;

    assign isEmpty  = (count_q == '0);
    assign isFull   = (count_q == CW'(DEPTH));
    assign memWaddr = AW'(count_q - CW'(1));
    assign memRaddr = AW'(count_q - CW'(2));

`ifdef RETSTACK_FAST_POP_EN
    assign bus.ready = 1'b1;
`else
    state_t state_q, state_d;

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign bus.ready = (state_q == ST_IDLE);
`endif

    // Request decode; in REFILL every request is ignored while TOS reloads from RAM.
    always_comb begin
        count_d = count_q;
        tos_d   = tos_q;
        ovf_d   = ovf_q & ~bus.clr_err;
        unf_d   = unf_q & ~bus.clr_err;
        rpInc   = RP_INC_HOLD;
        memWe   = 1'b0;
`ifndef RETSTACK_FAST_POP_EN
        state_d = state_q;
        if (state_q == ST_REFILL) begin
            tos_d   = memRdata;
            state_d = ST_IDLE;
        end else
`endif
        if (bus.push && bus.pop) begin
            tos_d = bus.push_data;
            if (isEmpty) begin
                count_d = CW'(1);
                rpInc   = RP_INC_UP;
                unf_d   = 1'b1;
            end
        end else if (bus.push) begin
            if (isFull) begin
                ovf_d = 1'b1;
            end else begin
                memWe   = !isEmpty;
                tos_d   = bus.push_data;
                count_d = count_q + CW'(1);
                rpInc   = RP_INC_UP;
            end
        end else if (bus.pop) begin
            if (isEmpty) begin
                unf_d = 1'b1;
            end else if (count_q == CW'(1)) begin
                tos_d   = '0;
                count_d = '0;
                rpInc   = RP_INC_DOWN;
            end else begin
                count_d = count_q - CW'(1);
                rpInc   = RP_INC_DOWN;
`ifdef RETSTACK_FAST_POP_EN
                tos_d   = memRdata;
`else
                state_d = ST_REFILL;
`endif
            end
        end
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
            tos_q   <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            tos_q   <= tos_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    retstack_mem #(
        .WIDTH  (WIDTH),
        .ENTRIES(DEPTH - 1),
        .AW     (AW)
    ) u_mem (
        .clk_i  (CLK),
        .we_i   (memWe),
        .waddr_i(memWaddr),
        .wdata_i(tos_q),
        .raddr_i(memRaddr),
        .rdata_o(memRdata)
    );

    assign bus.tos       = tos_q;
    assign bus.count     = count_q;
    assign bus.empty     = isEmpty;
    assign bus.full      = isFull;
    assign bus.overflow  = ovf_q;
    assign bus.underflow = unf_q;
    assign bus.rp_inc    = rpInc;
    assign bus.rp        = 16'(BASE) + 16'(count_q);

endmodule

// File: tb/tb_subsystem_retstack.sv
// Directed self-checking bench for subsystem_retstack (default build, synchronous-read RAM).
module tb_subsystem_retstack;

    logic CLK   = 1'b0;
    logic reset = 1'b0;
    int   compared   = 0;
    int   mismatched = 0;

    subsystem_retstack_if #(.WIDTH(16), .DEPTH(16)) bus ();

    subsystem_retstack #(
        .WIDTH(16),
        .DEPTH(16),
        .BASE (16384)
    ) dut (
        .CLK  (CLK),
        .reset(reset),
        .bus  (bus)
    );

    always #5 CLK = ~CLK;

    task automatic drive(input logic ps, input logic pp, input logic [15:0] d, input logic clr);
        bus.push      = ps;
        bus.pop       = pp;
        bus.push_data = d;
        bus.clr_err   = clr;
    endtask

    // Inputs change and outputs are sampled 1-2 time units after each rising edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic test_reset();
        drive(1'b0, 1'b0, 16'h0000, 1'b0);
        reset = 1'b0;
        repeat (2) @(posedge CLK);
        #3 reset = 1'b1;
        tick();
        compared++; if (bus.count !== 5'd0) begin mismatched++; $display("FAIL reset_count: got %0d expected 0", bus.count); end
        compared++; if (bus.tos !== 16'h0000) begin mismatched++; $display("FAIL reset_tos: got %h expected 0000", bus.tos); end
        compared++; if (bus.rp !== 16'd16384) begin mismatched++; $display("FAIL reset_rp: got %0d expected 16384", bus.rp); end
        compared++; if (bus.ready !== 1'b1) begin mismatched++; $display("FAIL reset_ready: got %b expected 1", bus.ready); end
        compared++; if (bus.rp_inc !== 2'b00) begin mismatched++; $display("FAIL reset_rp_inc: got %b expected 00", bus.rp_inc); end
        compared++; if ({bus.overflow, bus.underflow} !== 2'b00) begin mismatched++; $display("FAIL reset_flags: got %b expected 00", {bus.overflow, bus.underflow}); end
        compared++; if (bus.empty !== 1'b1) begin mismatched++; $display("FAIL reset_empty: got %b expected 1", bus.empty); end

        drive(1'b1, 1'b0, 16'h000A, 1'b0); tick();
        drive(1'b1, 1'b0, 16'h000B, 1'b0); tick();
        drive(1'b0, 1'b1, 16'h0000, 1'b0); tick();
        drive(1'b0, 1'b0, 16'h0000, 1'b0); settle();
        compared++; if (bus.ready !== 1'b0) begin mismatched++; $display("FAIL refill_ready: got %b expected 0", bus.ready); end
        #1 reset = 1'b0;
        #1;
        compared++; if (bus.count !== 5'd0) begin mismatched++; $display("FAIL midrefill_count: got %0d expected 0", bus.count); end
        compared++; if (bus.tos !== 16'h0000) begin mismatched++; $display("FAIL midrefill_tos: got %h expected 0000", bus.tos); end
        compared++; if (bus.rp !== 16'd16384) begin mismatched++; $display("FAIL midrefill_rp: got %0d expected 16384", bus.rp); end
        compared++; if (bus.ready !== 1'b1) begin mismatched++; $display("FAIL midrefill_ready: got %b expected 1", bus.ready); end
        compared++; if ({bus.overflow, bus.underflow} !== 2'b00) begin mismatched++; $display("FAIL midrefill_flags: got %b expected 00", {bus.overflow, bus.underflow}); end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_push();
        logic [15:0] vals [3];
        vals[0] = 16'h1111;
        vals[1] = 16'h2222;
        vals[2] = 16'h3333;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, vals[i], 1'b0);
            settle();
            compared++; if (bus.rp_inc !== 2'b01) begin mismatched++; $display("FAIL push_rp_inc[%0d]: got %b expected 01", i, bus.rp_inc); end
            tick();
        end
        drive(1'b0, 1'b0, 16'h0000, 1'b0); settle();
        compared++; if (bus.tos !== 16'h3333) begin mismatched++; $display("FAIL push_tos: got %h expected 3333", bus.tos); end
        compared++; if (bus.count !== 5'd3) begin mismatched++; $display("FAIL push_count: got %0d expected 3", bus.count); end
        compared++; if (bus.rp !== 16'd16387) begin mismatched++; $display("FAIL push_rp: got %0d expected 16387", bus.rp); end
    endtask

    task automatic test_pop();
        drive(1'b0, 1'b1, 16'h0000, 1'b0); settle();
        compared++; if (bus.tos !== 16'h3333) begin mismatched++; $display("FAIL pop_tos_same_cycle: got %h expected 3333", bus.tos); end
        compared++; if (bus.rp_inc !== 2'b10) begin mismatched++; $display("FAIL pop_rp_inc: got %b expected 10", bus.rp_inc); end
        tick();
        drive(1'b0, 1'b1, 16'h0000, 1'b0); settle();
        compared++; if (bus.ready !== 1'b0) begin mismatched++; $display("FAIL pop_refill_ready: got %b expected 0", bus.ready); end
        compared++; if (bus.rp_inc !== 2'b00) begin mismatched++; $display("FAIL pop_ignored_rp_inc: got %b expected 00", bus.rp_inc); end
        tick();
        drive(1'b0, 1'b0, 16'h0000, 1'b0); settle();
        compared++; if (bus.tos !== 16'h2222) begin mismatched++; $display("FAIL pop_tos_after: got %h expected 2222", bus.tos); end
        compared++; if (bus.ready !== 1'b1) begin mismatched++; $display("FAIL pop_ready_after: got %b expected 1", bus.ready); end
        compared++; if (bus.rp !== 16'd16386) begin mismatched++; $display("FAIL pop_rp_after: got %0d expected 16386", bus.rp); end
        compared++; if (bus.count !== 5'd2) begin mismatched++; $display("FAIL pop_count_after: got %0d expected 2", bus.count); end
    endtask

    task automatic test_replace();
        drive(1'b1, 1'b1, 16'h7777, 1'b0); settle();
        compared++; if (bus.rp_inc !== 2'b00) begin mismatched++; $display("FAIL replace_rp_inc: got %b expected 00", bus.rp_inc); end
        tick();
        drive(1'b0, 1'b0, 16'h0000, 1'b0); settle();
        compared++; if (bus.tos !== 16'h7777) begin mismatched++; $display("FAIL replace_tos: got %h expected 7777", bus.tos); end
        compared++; if (bus.count !== 5'd2) begin mismatched++; $display("FAIL replace_count: got %0d expected 2", bus.count); end
        compared++; if (bus.rp !== 16'd16386) begin mismatched++; $display("FAIL replace_rp: got %0d expected 16386", bus.rp); end
        drive(1'b0, 1'b1, 16'h0000, 1'b0); tick();
        drive(1'b0, 1'b0, 16'h0000, 1'b0); tick();
        compared++; if (bus.tos !== 16'h1111) begin mismatched++; $display("FAIL replace_ram_entry0: got %h expected 1111", bus.tos); end
        compared++; if (bus.count !== 5'd1) begin mismatched++; $display("FAIL replace_pop_count: got %0d expected 1", bus.count); end
        drive(1'b0, 1'b1, 16'h0000, 1'b0); settle();
        compared++; if (bus.rp_inc !== 2'b10) begin mismatched++; $display("FAIL last_pop_rp_inc: got %b expected 10", bus.rp_inc); end
        tick();
        drive(1'b0, 1'b0, 16'h0000, 1'b0); settle();
        compared++; if ({bus.empty, bus.count} !== {1'b1, 5'd0}) begin mismatched++; $display("FAIL last_pop_empty: got %b/%0d expected 1/0", bus.empty, bus.count); end
        compared++; if (bus.tos !== 16'h0000) begin mismatched++; $display("FAIL last_pop_tos: got %h expected 0000", bus.tos); end
        compared++; if (bus.ready !== 1'b1) begin mismatched++; $display("FAIL last_pop_ready: got %b expected 1", bus.ready); end
    endtask

    task automatic test_underflow();
        drive(1'b0, 1'b1, 16'h0000, 1'b0); settle();
        compared++; if (bus.rp_inc !== 2'b00) begin mismatched++; $display("FAIL underflow_rp_inc: got %b expected 00", bus.rp_inc); end
        tick();
        drive(1'b0, 1'b0, 16'h0000, 1'b0); settle();
        compared++; if (bus.underflow !== 1'b1) begin mismatched++; $display("FAIL underflow_flag: got %b expected 1", bus.underflow); end
        compared++; if (bus.rp !== 16'd16384) begin mismatched++; $display("FAIL underflow_rp: got %0d expected 16384", bus.rp); end
        drive(1'b0, 1'b0, 16'h0000, 1'b1); tick();
        drive(1'b0, 1'b0, 16'h0000, 1'b0); settle();
        compared++; if (bus.underflow !== 1'b0) begin mismatched++; $display("FAIL underflow_clear: got %b expected 0", bus.underflow); end
        drive(1'b1, 1'b1, 16'h5555, 1'b0); settle();
        compared++; if (bus.rp_inc !== 2'b01) begin mismatched++; $display("FAIL both_empty_rp_inc: got %b expected 01", bus.rp_inc); end
        tick();
        drive(1'b0, 1'b0, 16'h0000, 1'b0); settle();
        compared++; if (bus.count !== 5'd1) begin mismatched++; $display("FAIL both_empty_count: got %0d expected 1", bus.count); end
        compared++; if (bus.tos !== 16'h5555) begin mismatched++; $display("FAIL both_empty_tos: got %h expected 5555", bus.tos); end
        compared++; if (bus.underflow !== 1'b1) begin mismatched++; $display("FAIL both_empty_underflow: got %b expected 1", bus.underflow); end
        drive(1'b0, 1'b1, 16'h0000, 1'b1); tick();
        drive(1'b0, 1'b0, 16'h0000, 1'b0); settle();
        compared++; if ({bus.underflow, bus.count} !== {1'b0, 5'd0}) begin mismatched++; $display("FAIL clr_with_pop: got %b/%0d expected 0/0", bus.underflow, bus.count); end
        drive(1'b0, 1'b1, 16'h0000, 1'b1); tick();
        drive(1'b0, 1'b0, 16'h0000, 1'b0); settle();
        compared++; if (bus.underflow !== 1'b1) begin mismatched++; $display("FAIL clr_vs_new_error: got %b expected 1", bus.underflow); end
        drive(1'b0, 1'b0, 16'h0000, 1'b1); tick();
        drive(1'b0, 1'b0, 16'h0000, 1'b0); settle();
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 1'b0, 16'(16'h0100 + i), 1'b0);
            tick();
        end
        drive(1'b0, 1'b0, 16'h0000, 1'b0); settle();
        compared++; if ({bus.full, bus.count} !== {1'b1, 5'd16}) begin mismatched++; $display("FAIL fill_count: got %b/%0d expected 1/16", bus.full, bus.count); end
        compared++; if (bus.rp !== 16'd16400) begin mismatched++; $display("FAIL fill_rp: got %0d expected 16400", bus.rp); end
        drive(1'b1, 1'b0, 16'hAAAA, 1'b0); settle();
        compared++; if (bus.rp_inc !== 2'b00) begin mismatched++; $display("FAIL overflow_rp_inc: got %b expected 00", bus.rp_inc); end
        tick();
        drive(1'b0, 1'b0, 16'h0000, 1'b0); settle();
        compared++; if (bus.overflow !== 1'b1) begin mismatched++; $display("FAIL overflow_flag: got %b expected 1", bus.overflow); end
        compared++; if (bus.count !== 5'd16) begin mismatched++; $display("FAIL overflow_count: got %0d expected 16", bus.count); end
        compared++; if (bus.tos !== 16'h010F) begin mismatched++; $display("FAIL overflow_tos: got %h expected 010f", bus.tos); end
        drive(1'b0, 1'b0, 16'h0000, 1'b1); tick();
        drive(1'b0, 1'b0, 16'h0000, 1'b0); settle();
        compared++; if (bus.overflow !== 1'b0) begin mismatched++; $display("FAIL overflow_clear: got %b expected 0", bus.overflow); end
        drive(1'b1, 1'b1, 16'hBBBB, 1'b0); settle();
        compared++; if (bus.rp_inc !== 2'b00) begin mismatched++; $display("FAIL full_replace_rp_inc: got %b expected 00", bus.rp_inc); end
        tick();
        drive(1'b0, 1'b0, 16'h0000, 1'b0); settle();
        compared++; if ({bus.overflow, bus.count} !== {1'b0, 5'd16}) begin mismatched++; $display("FAIL full_replace_state: got %b/%0d expected 0/16", bus.overflow, bus.count); end
        compared++; if (bus.tos !== 16'hBBBB) begin mismatched++; $display("FAIL full_replace_tos: got %h expected bbbb", bus.tos); end
        drive(1'b0, 1'b1, 16'h0000, 1'b0); tick();
        drive(1'b0, 1'b0, 16'h0000, 1'b0); tick();
        compared++; if (bus.tos !== 16'h010E) begin mismatched++; $display("FAIL full_pop_tos: got %h expected 010e", bus.tos); end
        compared++; if ({bus.full, bus.count} !== {1'b0, 5'd15}) begin mismatched++; $display("FAIL full_pop_count: got %b/%0d expected 0/15", bus.full, bus.count); end
        compared++; if (bus.rp !== 16'd16399) begin mismatched++; $display("FAIL full_pop_rp: got %0d expected 16399", bus.rp); end
    endtask

    initial begin
        test_reset();
        test_push();
        test_pop();
        test_replace();
        test_underflow();
        test_overflow();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/subsystem_retstack.md
Name: subsystem_retstack

Overview:
Return-address stack that holds and pops the entries addressed by the return-stack pointer.
- Top-of-stack (TOS) is cached in a register; deeper entries live in a small synchronous-read RAM.
- Emits the 2-bit rp_inc code consumed by the rp adder (01 = +1, 10 = −1, 00 = hold), plus its own shadow rp.
- Sits between the control unit (call/return requests) and the rp adder subsystem.

Parameters:
- WIDTH, 16, entry width in bits.
- DEPTH, 16, total capacity including the TOS register; the RAM holds DEPTH−1 entries.
- BASE, 16384, rp value when the stack is empty.

Ports:
- CLK  input  1  clock, rising edge.
- reset  input  1  reset, asynchronous, active-low.
- push  input  1  push request.
- pop  input  1  pop request.
- push_data  input  WIDTH  return address to push.
- clr_err  input  1  synchronous clear of sticky error flags.
- ready  output  1  request accepted this cycle when high.
- tos  output  WIDTH  current top of stack; 0 when empty.
- rp  output  16  BASE + count.
- rp_inc  output  2  increment code for the rp adder.
- count  output  $clog2(DEPTH+1)  number of valid entries.
- empty  output  1  count == 0.
- full  output  1  count == DEPTH.
- overflow  output  1  sticky; a push was dropped while full.
- underflow  output  1  sticky; a pop was issued while empty.

Behaviour:
- Reset (asynchronous, active-low) forces:
  - State IDLE, count=0, tos=0, rp=BASE, rp_inc=00, ready=1.
  - overflow=0, underflow=0. RAM contents are don't-care.
- States: IDLE and REFILL.
  - ready=1 in IDLE, 0 in REFILL.
  - Requests while ready=0 are ignored: no flag change, rp_inc=00.
- rp_inc is combinational from the accepted request in the current cycle. It must match the rp change on the next edge.
- Push only, not full:
  - mem[count−1] ← tos when count ≥ 1; tos ← push_data; count+1; rp_inc=01.
  - Single cycle; stays in IDLE.
- Push only, full: dropped, overflow←1, rp_inc=00, state unchanged.
- Pop only, count ≥ 2:
  - count−1; RAM read issued at address count−2; rp_inc=10; go to REFILL.
  - Next edge: tos ← RAM read data, return to IDLE. Pop-to-next-accept latency is 2 cycles.
  - The caller samples tos in the same cycle as the pop.
- Pop only, count == 1: tos←0, count←0, rp_inc=10, stays in IDLE.
- Pop only, empty: underflow←1, rp_inc=00, no other change.
- Push and pop together:
  - count ≥ 1: replace, tos ← push_data; count, rp, RAM unchanged; rp_inc=00.
  - Empty: the push executes normally (count=1, rp_inc=01) and underflow←1.
  - Full with both: replace, with no overflow.
- clr_err clears both sticky flags. A new error in the same cycle wins and the flag sets.
- Widths: count never wraps. rp is 16-bit, BASE+count modulo 2^16.

Optional Feature:
RETSTACK_FAST_POP_EN
- Defined:
  - The RAM read is combinational, so pop loads tos directly from mem[count−2] in the same cycle.
  - No REFILL state; ready is tied to 1.
- Undefined: synchronous-read RAM with the REFILL bubble, as above.

Decomposition:
- Package retstack_pkg:
  - Constants RP_INC_HOLD=2'b00, RP_INC_UP=2'b01, RP_INC_DOWN=2'b10 (shared with the rp adder mux selection).
  - State enum {ST_IDLE, ST_REFILL}.
  - Default BASE value 16384.
- Sub-module retstack_mem: (DEPTH−1)×WIDTH RAM with one write port and one read port, synchronous read (combinational under RETSTACK_FAST_POP_EN).

Test Plan:
- Reset: assert reset=0 mid-REFILL → immediately count=0, tos=0, rp=16384, ready=1, flags 0.
- Push 0x1111, 0x2222, 0x3333 on consecutive cycles → rp_inc=01 each cycle, tos=0x3333, count=3, rp=16387.
- Pop from count=3:
  - Pop cycle: tos=0x3333 and rp_inc=10.
  - Next cycle: ready=0.
  - Following cycle: tos=0x2222, ready=1, rp=16386.
- Fill to DEPTH=16, then push 0xAAAA → dropped, overflow=1, count=16, rp_inc=00. Then clr_err → overflow=0.
- Pop on empty → underflow=1, rp stays 16384. Push and pop together on empty with 0x5555 → count=1, tos=0x5555, underflow=1.
- Push and pop together at count=2 with 0x7777 → tos=0x7777, count=2, rp_inc=00, RAM entry 0 unchanged. Check with a subsequent pop sequence.
